sign_extend_4to16: RTL and testbench
====================================

SIGN_EXTEND_4TO16 -- requirements
Module: sign_extend_4to16

Interface
REQ-001 Parameter IN_W, default 4: input field width in bits.
REQ-002 Parameter OUT_W, default 16: output word width in bits; OUT_W SHALL exceed IN_W.
REQ-003 Port clk, input, 1: the single clock; all registers SHALL be rising-edge triggered.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port Data_In, input, IN_W: immediate field (Rd) to be extended.
REQ-006 Port Mode, input, 2: extension mode.
- 00: sign-extend.
- 01: zero-extend.
- 10: sign-extend, then shift left 1.
- 11: reserved.
REQ-007 Port In_Valid, input, 1: qualifies Data_In/Mode for the registered path.
REQ-008 Port Data_Out, output, OUT_W: combinational extended result.
REQ-009 Port Data_Out_Q, output, OUT_W: registered extended result.
REQ-010 Port Out_Valid, output, 1: Data_Out_Q holds a result captured on an In_Valid cycle.

Function
REQ-011 Mode 00: Data_Out SHALL equal {(OUT_W-IN_W) copies of Data_In[IN_W-1], Data_In}.
REQ-012 Mode 01: Data_Out SHALL equal {(OUT_W-IN_W) zeros, Data_In}.
REQ-013 Mode 10: Data_Out SHALL equal the mode-00 result shifted left one bit, with the LSB 0 and the MSB of the pre-shift value discarded.
REQ-014 Mode 11: the block SHALL behave exactly as mode 00.
REQ-015 Data_Out SHALL be purely combinational with zero-cycle latency; it SHALL follow Data_In/Mode within the same delta, independent of clk, rst_n and In_Valid.
REQ-016 On each rising clk edge with In_Valid=1, Data_Out_Q SHALL load the current Data_Out value and Out_Valid SHALL be set to 1.
REQ-017 On a rising clk edge with In_Valid=0, Data_Out_Q SHALL hold its value and Out_Valid SHALL be cleared to 0.
REQ-018 The registered path SHALL have a latency of exactly 1 cycle; back-to-back In_Valid SHALL be accepted every cycle, with no stall or backpressure.
REQ-019 Boundary inputs SHALL behave as follows:
- All-zero input SHALL give 0 in every mode.
- Most-negative input 1000 (mode 00) SHALL give 0xFFF8.
- Most-positive input 0111 (mode 00) SHALL give 0x0007.
- Input 1111 SHALL give 0xFFFF (mode 00), 0x000F (mode 01), 0xFFFE (mode 10).

Reset
REQ-020 While rst_n=0, Data_Out_Q SHALL be 0 and Out_Valid SHALL be 0, immediately and regardless of clk.
REQ-021 Reset asserted mid-stream SHALL discard any in-flight result; the first capture after release SHALL occur on the first rising edge with rst_n=1 and In_Valid=1.
REQ-022 Data_Out SHALL remain functional during reset.

Structure
REQ-023 Mode encodings and the IN_W/OUT_W defaults SHALL reside in the shared CPU package.
REQ-024 The combinational extender SHALL be one sub-module, sign_extend_core; the top level SHALL add only the output register stage and valid flag.
REQ-025 The design SHALL contain no latches.

Verification
REQ-026 Combinational sign-extend, mode 00, inputs applied 5 ns apart:

| Data_In | Data_Out |
|---|---|
| 0001 | 0x0001 |
| 1001 | 0xFFF9 |
| 0011 | 0x0003 |
| 1011 | 0xFFFB |

REQ-027 Modes with Data_In=1011:
- Mode 01 -> 0x000B.
- Mode 10 -> 0xFFF6.
- Mode 11 -> 0xFFFB.
REQ-028 Registered path, mode 00: In_Valid=1 with Data_In=1000 at edge N -> Data_Out_Q=0xFFF8 and Out_Valid=1 after edge N; In_Valid=0 at edge N+1 -> Data_Out_Q=0xFFF8 held and Out_Valid=0.
REQ-029 Reset: load 0x0007, then pull rst_n low between edges -> Data_Out_Q=0x0000 and Out_Valid=0 at once; Data_Out still tracks Data_In.
REQ-030 Exhaustive sweep of all 16 inputs x 4 modes -> Data_Out matches REQ-011..014; Data_Out_Q matches one cycle later.

Source files
------------

// File: rtl/sign_extend_4to16_pkg.sv
// Shared CPU definitions for the immediate extender: default field widths
// and the extension mode encodings.
package sign_extend_4to16_pkg;

    localparam int IN_W_DEF  = 4;
    localparam int OUT_W_DEF = 16;

    typedef enum logic [1:0] {
        MODE_SEXT      = 2'b00,
        MODE_ZEXT      = 2'b01,
        MODE_SEXT_SHL1 = 2'b10,
        MODE_RSVD      = 2'b11
    } ext_mode_e;

endpackage

// File: rtl/sign_extend_4to16_core.sv
// Combinational immediate extender: sign, zero, or sign-then-shift-left-1.
module sign_extend_core
    import sign_extend_4to16_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  Data_In,
    input  logic [1:0]       Mode,
    output logic [OUT_W-1:0] Data_Out
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;

    assign sext = {{(OUT_W-IN_W){Data_In[IN_W-1]}}, Data_In};
    assign zext = {{(OUT_W-IN_W){1'b0}}, Data_In};

    // The reserved encoding falls through to plain sign extension.
    always_comb begin
        Data_Out = sext;
        case (ext_mode_e'(Mode))
            MODE_ZEXT:      Data_Out = zext;
            MODE_SEXT_SHL1: Data_Out = {sext[OUT_W-2:0], 1'b0};
            default:        Data_Out = sext;
        endcase
    end

endmodule

// File: rtl/sign_extend_4to16.sv
// Immediate extender with a combinational output plus a one-cycle registered
// copy and valid flag.
module sign_extend_4to16
    import sign_extend_4to16_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  Data_In,
    input  logic [1:0]       Mode,
    input  logic             In_Valid,
    output logic [OUT_W-1:0] Data_Out,
    output logic [OUT_W-1:0] Data_Out_Q,
    output logic             Out_Valid
);

    logic [OUT_W-1:0] data_q;
    logic [OUT_W-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    sign_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .Data_In  (Data_In),
        .Mode     (Mode),
        .Data_Out (Data_Out)
    );

    // Data holds across idle cycles; the valid flag only marks fresh captures.
    always_comb begin
        data_d  = data_q;
        valid_d = In_Valid;
        if (In_Valid) begin
            data_d = Data_Out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign Data_Out_Q = data_q;
    assign Out_Valid  = valid_q;

endmodule

// File: tb/tb_sign_extend_4to16.sv
// Directed self-checking bench for sign_extend_4to16: combinational modes,
// boundary inputs, registered path, async reset and a full sweep.
module tb_sign_extend_4to16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  Data_In;
    logic [1:0]  Mode;
    logic        In_Valid;
    logic [15:0] Data_Out;
    logic [15:0] Data_Out_Q;
    logic        Out_Valid;

    int compared   = 0;
    int mismatched = 0;

    sign_extend_4to16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Data_In    (Data_In),
        .Mode       (Mode),
        .In_Valid   (In_Valid),
        .Data_Out   (Data_Out),
        .Data_Out_Q (Data_Out_Q),
        .Out_Valid  (Out_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference built from signed arithmetic rather than bit replication.
    function automatic logic [15:0] refModel(input logic [3:0] din, input logic [1:0] md);
        logic signed [15:0] s;
        s = 16'($signed(din));
        case (md)
            2'b01:   refModel = {12'h000, din};
            2'b10:   refModel = 16'(s * 2);
            default: refModel = s;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] din, input logic [1:0] md, input logic vld);
        Data_In  = din;
        Mode     = md;
        In_Valid = vld;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'b1111, 2'b00, 1'b0);
        #1;
        checkOutput("reset_q", Data_Out_Q, 16'h0000);
        checkOutput("reset_valid", {15'b0, Out_Valid}, 16'h0000);
        checkOutput("reset_comb", Data_Out, 16'hFFFF);

        @(negedge clk);
        rst_n = 1'b1;

        // Mode 00 table, 5 ns apart
        applyStimulus(4'b0001, 2'b00, 1'b0); #5; checkOutput("sext_0001", Data_Out, 16'h0001);
        applyStimulus(4'b1001, 2'b00, 1'b0); #5; checkOutput("sext_1001", Data_Out, 16'hFFF9);
        applyStimulus(4'b0011, 2'b00, 1'b0); #5; checkOutput("sext_0011", Data_Out, 16'h0003);
        applyStimulus(4'b1011, 2'b00, 1'b0); #5; checkOutput("sext_1011", Data_Out, 16'hFFFB);

        // Modes with 1011
        applyStimulus(4'b1011, 2'b01, 1'b0); #1; checkOutput("zext_1011", Data_Out, 16'h000B);
        applyStimulus(4'b1011, 2'b10, 1'b0); #1; checkOutput("shl_1011", Data_Out, 16'hFFF6);
        applyStimulus(4'b1011, 2'b11, 1'b0); #1; checkOutput("rsvd_1011", Data_Out, 16'hFFFB);

        // Boundaries
        for (int m = 0; m < 4; m++) begin
            applyStimulus(4'b0000, 2'(m), 1'b0); #1;
            checkOutput("zero_in", Data_Out, 16'h0000);
        end
        applyStimulus(4'b1000, 2'b00, 1'b0); #1; checkOutput("most_neg", Data_Out, 16'hFFF8);
        applyStimulus(4'b0111, 2'b00, 1'b0); #1; checkOutput("most_pos", Data_Out, 16'h0007);
        applyStimulus(4'b1111, 2'b00, 1'b0); #1; checkOutput("ones_sext", Data_Out, 16'hFFFF);
        applyStimulus(4'b1111, 2'b01, 1'b0); #1; checkOutput("ones_zext", Data_Out, 16'h000F);
        applyStimulus(4'b1111, 2'b10, 1'b0); #1; checkOutput("ones_shl", Data_Out, 16'hFFFE);

        // Registered capture then hold
        @(negedge clk);
        applyStimulus(4'b1000, 2'b00, 1'b1);
        @(posedge clk); #1;
        checkOutput("reg_load_q", Data_Out_Q, 16'hFFF8);
        checkOutput("reg_load_valid", {15'b0, Out_Valid}, 16'h0001);
        applyStimulus(4'b0011, 2'b00, 1'b0);
        @(posedge clk); #1;
        checkOutput("reg_hold_q", Data_Out_Q, 16'hFFF8);
        checkOutput("reg_hold_valid", {15'b0, Out_Valid}, 16'h0000);

        // Mid-cycle async reset
        @(negedge clk);
        applyStimulus(4'b0111, 2'b00, 1'b1);
        @(posedge clk); #1;
        checkOutput("pre_rst_q", Data_Out_Q, 16'h0007);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_q", Data_Out_Q, 16'h0000);
        checkOutput("async_rst_valid", {15'b0, Out_Valid}, 16'h0000);
        applyStimulus(4'b1001, 2'b00, 1'b1); #1;
        checkOutput("rst_comb", Data_Out, 16'hFFF9);
        @(posedge clk); #1;
        checkOutput("rst_hold_q", Data_Out_Q, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1001, 2'b00, 1'b0);
        @(posedge clk); #1;
        checkOutput("post_rst_idle_valid", {15'b0, Out_Valid}, 16'h0000);
        checkOutput("post_rst_idle_q", Data_Out_Q, 16'h0000);
        @(negedge clk);
        applyStimulus(4'b0011, 2'b00, 1'b1);
        @(posedge clk); #1;
        checkOutput("first_cap_q", Data_Out_Q, 16'h0003);
        checkOutput("first_cap_valid", {15'b0, Out_Valid}, 16'h0001);

        // Back-to-back sweep of all inputs and modes
        for (int m = 0; m < 4; m++) begin
            for (int d = 0; d < 16; d++) begin
                @(negedge clk);
                applyStimulus(4'(d), 2'(m), 1'b1);
                #1;
                checkOutput("sweep_comb", Data_Out, refModel(4'(d), 2'(m)));
                @(posedge clk); #1;
                checkOutput("sweep_q", Data_Out_Q, refModel(4'(d), 2'(m)));
                checkOutput("sweep_valid", {15'b0, Out_Valid}, 16'h0001);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
